// File: rtl/go_move_commit.sv
// Legality check and commit stage for 9x9 Go moves; owns the board, turn, move counter and pass tracking.
// Optional GO_LAST_MOVE_EN adds last_move / last_move_valid reporting of the most recent committed proposal.
module go_move_commit #(
  parameter logic [1:0] LOCAL_COLOR = 2'b01
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  local_valid,
  input  logic [7:0]            local_move,
  input  logic                  remote_valid,
  input  logic [7:0]            remote_move,
  output logic [8:0][8:0][1:0]  board,
  output logic [1:0]            turn_color,
  output logic                  my_turn,
  output logic                  move_ack,
  output logic                  move_nack,
  output logic [7:0]            move_count,
  output logic                  game_over
`ifdef GO_LAST_MOVE_EN
  ,
  output logic [7:0]            last_move,
  output logic                  last_move_valid
`endif
);

  localparam logic [7:0] PASS_CODE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  pend_reg, pend_next;
  logic [1:0]  turn_reg, turn_next;
  logic [7:0]  count_reg, count_next;
  logic [1:0]  streak_reg, streak_next;
  logic        over_reg, over_next;
  logic        ack_reg, ack_next;
  logic        nack_reg, nack_next;
  logic        stone_we;

  logic        local_owns;
  logic        is_pass;
  logic        in_range;
  logic        target_busy;
  logic        stone_legal;
  logic [80:0] cell_busy;

  assign local_owns  = (turn_reg == LOCAL_COLOR);
  assign is_pass     = (pend_reg == PASS_CODE);
  assign in_range    = (pend_reg[7:4] <= 4'd8) && (pend_reg[3:0] <= 4'd8);
  assign target_busy = |cell_busy;
  assign stone_legal = !is_pass && in_range && !target_busy;

  // Each cell is its own register; the pending address is decoded per cell, so an
  // out-of-range row/col simply matches nothing.
  genvar gi;
  generate
    for (gi = 0; gi < 81; gi++) begin : g_cell
      localparam int ROW = gi / 9;
      localparam int COL = gi % 9;
      localparam logic [7:0] ADDR = 8'((ROW << 4) | COL);

      logic [1:0] cell_reg;
      logic       hit;

      assign hit           = (pend_reg == ADDR);
      assign cell_busy[gi] = hit && (cell_reg != 2'b00);
      assign board[ROW][COL] = cell_reg;

      always_ff @(posedge clk_in) begin
        if (reset) begin
          cell_reg <= 2'b00;
        end else if (stone_we && hit) begin
          cell_reg <= turn_reg;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_reg  <= IDLE;
      pend_reg   <= 8'h00;
      turn_reg   <= 2'b01;
      count_reg  <= 8'h00;
      streak_reg <= 2'd0;
      over_reg   <= 1'b0;
      ack_reg    <= 1'b0;
      nack_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pend_reg   <= pend_next;
      turn_reg   <= turn_next;
      count_reg  <= count_next;
      streak_reg <= streak_next;
      over_reg   <= over_next;
      ack_reg    <= ack_next;
      nack_reg   <= nack_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pend_next   = pend_reg;
    turn_next   = turn_reg;
    count_next  = count_reg;
    streak_next = streak_reg;
    over_next   = over_reg;
    ack_next    = 1'b0;
    nack_next   = 1'b0;
    stone_we    = 1'b0;

    case (state_reg)
      IDLE: begin
        // Only the side owning the turn is listened to; the other pulse is dropped.
        if (!over_reg) begin
          if (local_owns && local_valid) begin
            pend_next  = local_move;
            state_next = CHECK;
          end else if (!local_owns && remote_valid) begin
            pend_next  = remote_move;
            state_next = CHECK;
          end
        end
      end

      CHECK: begin
        if (is_pass || stone_legal) begin
          ack_next   = 1'b1;
          turn_next  = (turn_reg == 2'b01) ? 2'b10 : 2'b01;
          count_next = (count_reg == 8'hFF) ? count_reg : count_reg + 8'd1;
          if (is_pass) begin
            streak_next = (streak_reg == 2'd2) ? 2'd2 : streak_reg + 2'd1;
            over_next   = over_reg | (streak_next == 2'd2);
          end else begin
            stone_we    = 1'b1;
            streak_next = 2'd0;
          end
        end else begin
          nack_next = 1'b1;
        end
        state_next = RESP;
      end

      RESP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign turn_color = turn_reg;
  assign move_count = count_reg;
  assign game_over  = over_reg;
  assign move_ack   = ack_reg;
  assign move_nack  = nack_reg;
  assign my_turn    = (state_reg == IDLE) && local_owns && !over_reg;

`ifdef GO_LAST_MOVE_EN
  logic [7:0] last_move_reg;
  logic       last_valid_reg;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      last_move_reg  <= 8'h00;
      last_valid_reg <= 1'b0;
    end else if (ack_next) begin
      last_move_reg  <= pend_reg;
      last_valid_reg <= 1'b1;
    end
  end

  assign last_move       = last_move_reg;
  assign last_move_valid = last_valid_reg;
`endif

endmodule
